universal_shift_reg: RTL and testbench

Parametrised universal shift register: the next generation of the team's fixed 8-bit serial-in/parallel-out DFF shift register. It adds configurable width, shift-left/shift-right, rotate, parallel load and clear modes, a clock enable, and a shift counter that pulses `done` once a full word has been shifted. It sits between serial links and parallel datapaths as a SIPO/PISO converter.

---
 rtl/shift_reg_pkg.sv | 27 ++
 rtl/shift_counter.sv | 34 +++
 rtl/universal_shift_reg.sv | 66 ++++++
 tb/tb_universal_shift_reg.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the universal shift register.
package shift_reg_pkg;

    typedef enum logic [2:0] {
        HOLD  = 3'd0,
        SHL   = 3'd1,
        SHR   = 3'd2,
        ROL   = 3'd3,
        ROR   = 3'd4,
        LOAD  = 3'd5,
        CLEAR = 3'd6,
        RSVD  = 3'd7
    } mode_t;

    localparam int SR_DEFAULT_WIDTH = 8;

    // True for the four modes that move data by one bit position.
    function automatic logic is_shift(input mode_t m);
        return (m == SHL) || (m == SHR) || (m == ROL) || (m == ROR);
    endfunction

    // True for the modes that overwrite the whole word and start a new one.
    function automatic logic is_restart(input mode_t m);
        return (m == LOAD) || (m == CLEAR);
    endfunction

endpackage

// File: rtl/shift_counter.sv
// Counts shift edges within a word and pulses wrap for one cycle when the
// MAX-th shift of the word lands. Clear wins over increment.
module shift_counter #(
    parameter  int MAX = 8,
    localparam int CW  = $clog2(MAX + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          inc,
    input  logic          clr,
    output logic [CW-1:0] cnt,
    output logic          wrap
);

    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    // Counter register and registered end-of-word pulse (low by default every edge).
    always_ff @(posedge clk) begin
        wrap <= 1'b0;
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc) begin
            if (cnt == LAST) begin
                cnt  <= '0;
                wrap <= 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: shift/rotate in both directions, parallel load,
// clear and hold, with a per-word shift counter that pulses done.
module universal_shift_reg
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = SR_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  mode_t            mode,
    input  logic             sIn,
    input  logic [WIDTH-1:0] pIn,
    output logic [WIDTH-1:0] PO,
    output logic             SO,
    output logic             done
);

    localparam int CW = $clog2(WIDTH + 1);

    // Bit position within the current word; only the wrap pulse is exported.
    logic [CW-1:0] cnt_unused;
    logic          cnt_inc;
    logic          cnt_clr;

    // Counter only advances or restarts on enabled edges; reset is handled inside.
    always_comb begin
        cnt_inc = en && is_shift(mode);
        cnt_clr = en && is_restart(mode);
    end

    shift_counter #(.MAX(WIDTH)) u_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (cnt_inc),
        .clr  (cnt_clr),
        .cnt  (cnt_unused),
        .wrap (done)
    );

    // Data register: reset first, then enable, then the mode mux.
    always_ff @(posedge clk) begin
        if (!rst) begin
            PO <= '0;
        end else if (en) begin
            case (mode)
                SHL:     PO <= {PO[WIDTH-2:0], sIn};
                SHR:     PO <= {sIn, PO[WIDTH-1:1]};
                ROL:     PO <= {PO[WIDTH-2:0], PO[WIDTH-1]};
                ROR:     PO <= {PO[0], PO[WIDTH-1:1]};
                LOAD:    PO <= pIn;
                CLEAR:   PO <= '0;
                default: PO <= PO;
            endcase
        end
    end

    // Serial out taps the end the data is leaving from in right-going modes.
    always_comb begin
        SO = PO[WIDTH-1];
        if ((mode == SHR) || (mode == ROR)) begin
            SO = PO[0];
        end
    end

endmodule

// File: tb/tb_universal_shift_reg.sv
module tb_universal_shift_reg;
    import shift_reg_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    mode_t        mode;
    logic         sIn;
    logic [W-1:0] pIn;
    logic [W-1:0] PO;
    logic         SO;
    logic         done;

    int applied     = 0;
    int miscompares = 0;

    // reference model state
    logic [W-1:0] m_po;
    int           m_shifts;
    logic         m_done;
    bit           m_valid = 1'b0;

    typedef struct {
        logic         r;
        logic         e;
        mode_t        m;
        logic         s;
        logic [W-1:0] p;
        logic [W-1:0] po;
        logic         dn;
    } vec_t;

    vec_t tbl[$];

    always #5 clk = ~clk;

    universal_shift_reg #(.WIDTH(W)) dut (
        .clk  (clk),
        .rst  (rst),
        .en   (en),
        .mode (mode),
        .sIn  (sIn),
        .pIn  (pIn),
        .PO   (PO),
        .SO   (SO),
        .done (done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_so(input logic [W-1:0] po, input mode_t m);
        if (m == SHR || m == ROR) return po[0];
        return po[W-1];
    endfunction

    // Model: word arithmetic on integers; done whenever the shift total since
    // the last restart reaches a multiple of W.
    task automatic model_edge(input logic r, input logic e, input mode_t m, input logic s,
                              input logic [W-1:0] p);
        int v;
        int top;
        v      = int'(m_po);
        top    = 2 ** (W - 1);
        m_done = 1'b0;
        if (!r) begin
            v        = 0;
            m_shifts = 0;
        end else if (e) begin
            case (m)
                SHL:   v = (v * 2 + int'(s)) % (2 ** W);
                SHR:   v = v / 2 + int'(s) * top;
                ROL:   v = (v * 2) % (2 ** W) + v / top;
                ROR:   v = v / 2 + (v % 2) * top;
                LOAD:  begin v = int'(p); m_shifts = 0; end
                CLEAR: begin v = 0;       m_shifts = 0; end
                default: ;
            endcase
            if (m == SHL || m == SHR || m == ROL || m == ROR) begin
                m_shifts++;
                m_done = (m_shifts % W) == 0;
            end
        end
        m_po = W'(v);
    endtask

    task automatic step(input logic r, input logic e, input mode_t m, input logic s,
                        input logic [W-1:0] p);
        rst = r; en = e; mode = m; sIn = s; pIn = p;
        #1;
        if (m_valid) chk("so_pre_edge", 32'(SO), 32'(exp_so(m_po, m)));
        @(posedge clk);
        #1;
        model_edge(r, e, m, s, p);
        m_valid = 1'b1;
        chk("po", 32'(PO), 32'(m_po));
        chk("done", 32'(done), 32'(m_done));
        chk("so", 32'(SO), 32'(exp_so(m_po, m)));
    endtask

    initial begin
        logic [W-1:0] a5;
        logic [W-1:0] frozen;
        int           pulses;

        // reset with load requested; then SIPO, hold, SHR fill
        tbl.push_back('{1'b0, 1'b1, LOAD,  1'b0, 8'hFF, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b1, 8'h00, 8'h01, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b0, 8'h00, 8'h02, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b1, 8'h00, 8'h05, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b1, 8'h00, 8'h0B, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b0, 8'h00, 8'h16, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b0, 8'h00, 8'h2C, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b1, 8'h00, 8'h59, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHL,   1'b0, 8'h00, 8'hB2, 1'b1});
        tbl.push_back('{1'b1, 1'b1, HOLD,  1'b1, 8'h00, 8'hB2, 1'b0});
        tbl.push_back('{1'b1, 1'b1, CLEAR, 1'b1, 8'h3C, 8'h00, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHR,   1'b1, 8'h00, 8'h80, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHR,   1'b1, 8'h00, 8'hC0, 1'b0});
        tbl.push_back('{1'b1, 1'b1, SHR,   1'b1, 8'h00, 8'hE0, 1'b0});

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].e, tbl[i].m, tbl[i].s, tbl[i].p);
            chk("tbl_po", 32'(PO), 32'(tbl[i].po));
            chk("tbl_done", 32'(done), 32'(tbl[i].dn));
            if (i == 0) chk("reset_so", 32'(SO), 32'h0);
        end

        // PISO rotate: serial stream is the loaded word LSB first
        a5 = 8'hA5;
        pulses = 0;
        step(1'b1, 1'b1, LOAD, 1'b0, a5);
        chk("load_po", 32'(PO), 32'hA5);
        for (int i = 0; i < W; i++) begin
            rst = 1'b1; en = 1'b1; mode = ROR;
            #1;
            chk("ror_so", 32'(SO), 32'(a5[i]));
            step(1'b1, 1'b1, ROR, 1'b0, '0);
            if (done) pulses++;
        end
        chk("ror_po_back", 32'(PO), 32'hA5);
        chk("ror_pulses", 32'(pulses), 32'd1);

        // reset mid-word: partial word is discarded
        for (int i = 0; i < 5; i++) step(1'b1, 1'b1, SHL, 1'b1, '0);
        step(1'b0, 1'b1, SHL, 1'b1, '0);
        chk("midrst_po", 32'(PO), 32'h0);
        pulses = 0;
        for (int i = 0; i < W - 1; i++) begin
            step(1'b1, 1'b1, SHL, 1'(i % 2), '0);
            if (done) pulses++;
        end
        chk("midrst_early_done", 32'(pulses), 32'd0);
        step(1'b1, 1'b1, SHL, 1'b1, '0);
        chk("midrst_done", 32'(done), 32'd1);

        // enable low and reserved mode freeze the word in progress
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, SHL, 1'b1, '0);
        frozen = PO;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b0, SHL, 1'b0, 8'h5A);
            chk("en_low_po", 32'(PO), 32'(frozen));
            if (done) pulses++;
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 1'b1, RSVD, 1'b0, 8'h5A);
            chk("rsvd_po", 32'(PO), 32'(frozen));
            if (done) pulses++;
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, SHL, 1'b0, '0);
            if (done) pulses++;
        end
        chk("freeze_no_done", 32'(pulses), 32'd0);
        step(1'b1, 1'b1, SHL, 1'b0, '0);
        chk("freeze_done", 32'(done), 32'd1);

        // randomized traffic against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(49) != 0),
                 ($urandom_range(5) != 0),
                 mode_t'($urandom_range(7)),
                 1'($urandom_range(1)),
                 W'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
